// File: rtl/ip_packet_tx.sv
// Ethernet II + IPv4 frame transmitter: captures one payload plus addresses, then streams the frame
// byte-wise over AXI-Stream. Define IP_TX_CHECKSUM_EN to build the header checksum accumulator.
`timescale 1ns/1ps

module ip_packet_tx #(
    parameter int unsigned USER_DATA_BYTES = 2,
    parameter logic [7:0]  IP_PROTOCOL     = 8'hFD,
    parameter logic [7:0]  IP_TTL          = 8'd64
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0]                  DST_IP_ADDRESS,
    input  logic [47:0]                  DST_MAC_ADDRESS,
    input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
    input  logic                         FRAME_VALID,
    output logic                         FRAME_READY,
    output logic [7:0]                   MAC_DATA_IN,
    output logic                         MAC_DATA_VALID,
    input  logic                         MAC_DATA_READY,
    output logic                         MAC_DATA_LAST
);

    localparam int unsigned PadBytes = (USER_DATA_BYTES < 26) ? 26 - USER_DATA_BYTES : 0;
    localparam logic [15:0] TotalLen = 16'(20 + USER_DATA_BYTES);
    localparam logic [15:0] UdLast   = 16'(USER_DATA_BYTES - 1);
    localparam logic [15:0] PadLast  = (PadBytes == 0) ? 16'd0 : 16'(PadBytes - 1);

    typedef enum logic [2:0] {
        StIdle,
        StEthHdr,
        StIpHdr,
        StUserData,
        StPad
    } state_e;

    state_e                       state_q, state_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic                         frame_ready_q;
    logic [15:0]                  ident_q;
    logic [47:0]                  dst_mac_q, src_mac_q;
    logic [31:0]                  dst_ip_q, src_ip_q;
    logic [USER_DATA_BYTES*8-1:0] data_q;
    logic [15:0]                  csum_value;
    logic                         capture;
    logic                         beat;
    logic [111:0]                 eth_hdr;
    logic [159:0]                 ip_hdr;

    assign capture     = FRAME_VALID && frame_ready_q;
    assign beat        = MAC_DATA_VALID && MAC_DATA_READY;
    assign FRAME_READY = frame_ready_q;

    // Byte k of each header lives at bits [8k+7:8k].
    assign eth_hdr = {8'h00, 8'h08, src_mac_q, dst_mac_q};
    assign ip_hdr  = {dst_ip_q, src_ip_q, csum_value[7:0], csum_value[15:8], IP_PROTOCOL, IP_TTL,
                      8'h00, 8'h40, ident_q[7:0], ident_q[15:8], TotalLen[7:0], TotalLen[15:8],
                      8'h00, 8'h45};

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            frame_ready_q <= 1'b0;
            ident_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_ready_q <= (state_d == StIdle);
            if (beat && MAC_DATA_LAST) begin
                ident_q <= ident_q + 16'd1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            dst_mac_q <= '0;
            src_mac_q <= '0;
            dst_ip_q  <= '0;
            src_ip_q  <= '0;
            data_q    <= '0;
        end else if (capture) begin
            dst_mac_q <= DST_MAC_ADDRESS;
            src_mac_q <= ACCELERATOR_MAC_ADDRESS;
            dst_ip_q  <= DST_IP_ADDRESS;
            src_ip_q  <= ACCELERATOR_IP_ADDRESS;
            data_q    <= DATA_FRAME;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d = StEthHdr;
                    cnt_d   = '0;
                end
            end
            StEthHdr: begin
                if (beat) begin
                    if (cnt_q == 16'd13) begin
                        state_d = StIpHdr;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StIpHdr: begin
                if (beat) begin
                    if (cnt_q == 16'd19) begin
                        state_d = StUserData;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StUserData: begin
                if (beat) begin
                    if (cnt_q == UdLast) begin
                        state_d = (PadBytes == 0) ? StIdle : StPad;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StPad: begin
                if (beat) begin
                    if (cnt_q == PadLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, so they hold while the MAC stalls.
    always_comb begin
        MAC_DATA_VALID = (state_q != StIdle);
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_IN    = 8'h00;
        case (state_q)
            StEthHdr: begin
                for (int i = 0; i < 14; i++) begin
                    if (cnt_q == 16'(i)) MAC_DATA_IN = eth_hdr[8*i +: 8];
                end
            end
            StIpHdr: begin
                for (int i = 0; i < 20; i++) begin
                    if (cnt_q == 16'(i)) MAC_DATA_IN = ip_hdr[8*i +: 8];
                end
            end
            StUserData: begin
                for (int i = 0; i < int'(USER_DATA_BYTES); i++) begin
                    if (cnt_q == 16'(i)) MAC_DATA_IN = data_q[8*i +: 8];
                end
                MAC_DATA_LAST = (PadBytes == 0) && (cnt_q == UdLast);
            end
            StPad: begin
                MAC_DATA_LAST = (cnt_q == PadLast);
            end
            default: ;
        endcase
    end

`ifdef IP_TX_CHECKSUM_EN
    logic [19:0] csum_acc_q;
    logic [3:0]  csum_idx_q;
    logic [15:0] csum_q;
    logic [15:0] csum_word;
    logic [16:0] csum_fold1;
    logic [15:0] csum_fold2;

    always_comb begin
        csum_word = 16'h0000;
        case (csum_idx_q)
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = TotalLen;
            4'd2:    csum_word = ident_q;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {IP_TTL, IP_PROTOCOL};
            4'd6:    csum_word = {src_ip_q[7:0], src_ip_q[15:8]};
            4'd7:    csum_word = {src_ip_q[23:16], src_ip_q[31:24]};
            4'd8:    csum_word = {dst_ip_q[7:0], dst_ip_q[15:8]};
            4'd9:    csum_word = {dst_ip_q[23:16], dst_ip_q[31:24]};
            default: csum_word = 16'h0000;
        endcase
    end

    // Second fold cannot carry again: after the first, a carry leaves at most 0xE in the low half.
    assign csum_fold1 = {1'b0, csum_acc_q[15:0]} + {13'b0, csum_acc_q[19:16]};
    assign csum_fold2 = csum_fold1[15:0] + {15'b0, csum_fold1[16]};

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            csum_acc_q <= '0;
            csum_idx_q <= 4'd11;
            csum_q     <= '0;
        end else if (capture) begin
            csum_acc_q <= '0;
            csum_idx_q <= 4'd0;
        end else if (csum_idx_q < 4'd10) begin
            csum_acc_q <= csum_acc_q + {4'b0, csum_word};
            csum_idx_q <= csum_idx_q + 4'd1;
        end else if (csum_idx_q == 4'd10) begin
            csum_q     <= ~csum_fold2;
            csum_idx_q <= 4'd11;
        end
    end

    assign csum_value = csum_q;
`else
    assign csum_value = 16'h0000;
`endif

endmodule

// File: tb/tb_ip_packet_tx.sv
// Scoreboard bench for ip_packet_tx: a 2-byte-payload instance (padded) and a 30-byte instance
// (no pad); stimulus pushes expected frames, negedge monitors pop and compare.
`timescale 1ns/1ps

module tb_ip_packet_tx;

    localparam int unsigned UdA = 2;
    localparam int unsigned UdB = 30;
    localparam int FA = 60;
    localparam int FB = 64;

    logic ACLK = 1'b0;
    logic ARESET = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   bp = 1'b0;

    logic [47:0] dst_mac = 48'h665544332211;
    logic [47:0] src_mac = 48'hCCBBAA998877;
    logic [31:0] src_ip  = 32'h0A01A8C0;
    logic [31:0] dst_ip  = 32'h0101A8C0;

    logic [15:0]  frame_a = '0;
    logic         fv_a = 1'b0, fr_a, mv_a, ml_a, mr_a = 1'b1;
    logic [7:0]   md_a;
    logic [239:0] frame_b = '0;
    logic         fv_b = 1'b0, fr_b, mv_b, ml_b, mr_b = 1'b1;
    logic [7:0]   md_b;

    ip_packet_tx #(.USER_DATA_BYTES(UdA)) dut_a (
        .ACLK(ACLK), .ARESET(ARESET),
        .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
        .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
        .DATA_FRAME(frame_a), .FRAME_VALID(fv_a), .FRAME_READY(fr_a),
        .MAC_DATA_IN(md_a), .MAC_DATA_VALID(mv_a), .MAC_DATA_READY(mr_a), .MAC_DATA_LAST(ml_a)
    );

    ip_packet_tx #(.USER_DATA_BYTES(UdB)) dut_b (
        .ACLK(ACLK), .ARESET(ARESET),
        .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
        .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
        .DATA_FRAME(frame_b), .FRAME_VALID(fv_b), .FRAME_READY(fr_b),
        .MAC_DATA_IN(md_b), .MAC_DATA_VALID(mv_b), .MAC_DATA_READY(mr_b), .MAC_DATA_LAST(ml_b)
    );

    initial forever begin
        #5 ACLK = 1'b1;
        cyc++;
        #5 ACLK = 1'b0;
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        mr_a = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        mr_b = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
    endtask

    // Expected frame model: {last, byte} per entry.
    logic [8:0] fb [64];
    int         fn;

    task automatic build(input int ud, input logic [15:0] id, input logic [239:0] data);
        logic [15:0] tl, cs;
        int unsigned s;
        tl = 16'(20 + ud);
        s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h40FD
            + 32'({src_ip[7:0], src_ip[15:8]}) + 32'({src_ip[23:16], src_ip[31:24]})
            + 32'({dst_ip[7:0], dst_ip[15:8]}) + 32'({dst_ip[23:16], dst_ip[31:24]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
`ifdef IP_TX_CHECKSUM_EN
        cs = ~s[15:0];
`else
        cs = 16'h0000;
`endif
        fn = 34 + ((ud > 26) ? ud : 26);
        for (int i = 0; i < 64; i++) fb[i] = 9'h000;
        for (int i = 0; i < 6; i++) begin
            fb[i]     = {1'b0, dst_mac[8*i +: 8]};
            fb[6 + i] = {1'b0, src_mac[8*i +: 8]};
        end
        fb[12] = 9'h008; fb[13] = 9'h000; fb[14] = 9'h045; fb[15] = 9'h000;
        fb[16] = {1'b0, tl[15:8]}; fb[17] = {1'b0, tl[7:0]};
        fb[18] = {1'b0, id[15:8]}; fb[19] = {1'b0, id[7:0]};
        fb[20] = 9'h040; fb[21] = 9'h000; fb[22] = 9'h040; fb[23] = 9'h0FD;
        fb[24] = {1'b0, cs[15:8]}; fb[25] = {1'b0, cs[7:0]};
        for (int i = 0; i < 4; i++) begin
            fb[26 + i] = {1'b0, src_ip[8*i +: 8]};
            fb[30 + i] = {1'b0, dst_ip[8*i +: 8]};
        end
        for (int i = 0; i < ud; i++) fb[34 + i] = {1'b0, data[8*i +: 8]};
        fb[fn - 1][8] = 1'b1;
    endtask

    logic [8:0] q_a[$], q_b[$];
    logic [8:0] held_a, held_b;
    bit         pend_a = 0, pend_b = 0, done_a = 0, done_b = 0;
    int         acc_a = 0, acc_b = 0, stalls_a = 0, stalls_b = 0;
    int         last_edge_a = 0, last_edge_b = 0, cap_a = 0, cap_b = 0;

    always @(negedge ACLK) begin
        logic [8:0] e;
        if (!ARESET) begin
            pend_a = 0;
        end else begin
            if (pend_a) begin
                check("a_hold_valid", 32'(mv_a), 32'h1);
                check("a_hold_data_last", 32'({ml_a, md_a}), 32'(held_a));
            end
            if (mv_a && mr_a) begin
                if (q_a.size() == 0) begin
                    fail_now("a_unexpected_byte");
                end else begin
                    e = q_a.pop_front();
                    check($sformatf("a_byte%0d", acc_a), 32'({ml_a, md_a}), 32'(e));
                    acc_a++;
                    if (e[8]) begin
                        last_edge_a = cyc + 1;
                        done_a = 1;
                    end
                end
            end
            pend_a = mv_a && !mr_a;
            held_a = {ml_a, md_a};
            if (pend_a) stalls_a++;
        end
    end

    always @(negedge ACLK) begin
        logic [8:0] e;
        if (!ARESET) begin
            pend_b = 0;
        end else begin
            if (pend_b) begin
                check("b_hold_valid", 32'(mv_b), 32'h1);
                check("b_hold_data_last", 32'({ml_b, md_b}), 32'(held_b));
            end
            if (mv_b && mr_b) begin
                if (q_b.size() == 0) begin
                    fail_now("b_unexpected_byte");
                end else begin
                    e = q_b.pop_front();
                    check($sformatf("b_byte%0d", acc_b), 32'({ml_b, md_b}), 32'(e));
                    acc_b++;
                    if (e[8]) begin
                        last_edge_b = cyc + 1;
                        done_b = 1;
                    end
                end
            end
            pend_b = mv_b && !mr_b;
            held_b = {ml_b, md_b};
            if (pend_b) stalls_b++;
        end
    end

    task automatic start_a(input logic [15:0] data, input logic [15:0] id);
        bit ok = 0;
        build(UdA, id, {224'b0, data});
        for (int i = 0; i < fn; i++) q_a.push_back(fb[i]);
        @(negedge ACLK);
        frame_a = data;
        fv_a = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (fr_a) begin ok = 1; break; end
            @(negedge ACLK);
        end
        if (!ok) begin
            fail_now("a_capture_ready");
            fv_a = 1'b0;
            return;
        end
        @(posedge ACLK);
        #1;
        cap_a = cyc;
        fv_a = 1'b0;
        frame_a = 16'hDEAD;
        stalls_a = 0;
        done_a = 0;
        check("a_ready_low_after_capture", 32'(fr_a), 32'h0);
    endtask

    task automatic wait_a();
        bit ok = 0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge ACLK);
            #1;
            if (done_a) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("a_frame_end");
            return;
        end
        check("a_last_accept_cycle", 32'(last_edge_a), 32'(cap_a + FA + stalls_a));
        check("a_ready_after_frame", 32'(fr_a), 32'h1);
        check("a_queue_drained", 32'(q_a.size()), 32'h0);
    endtask

    task automatic start_b(input logic [239:0] data, input logic [15:0] id);
        bit ok = 0;
        build(UdB, id, data);
        for (int i = 0; i < fn; i++) q_b.push_back(fb[i]);
        @(negedge ACLK);
        frame_b = data;
        fv_b = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (fr_b) begin ok = 1; break; end
            @(negedge ACLK);
        end
        if (!ok) begin
            fail_now("b_capture_ready");
            fv_b = 1'b0;
            return;
        end
        @(posedge ACLK);
        #1;
        cap_b = cyc;
        fv_b = 1'b0;
        frame_b = '1;
        stalls_b = 0;
        done_b = 0;
        check("b_ready_low_after_capture", 32'(fr_b), 32'h0);
    endtask

    task automatic wait_b();
        bit ok = 0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge ACLK);
            #1;
            if (done_b) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("b_frame_end");
            return;
        end
        check("b_last_accept_cycle", 32'(last_edge_b), 32'(cap_b + FB + stalls_b));
        check("b_ready_after_frame", 32'(fr_b), 32'h1);
        check("b_queue_drained", 32'(q_b.size()), 32'h0);
    endtask

    initial begin
        logic [239:0] pay_b;
        int prev_end, a0;
        bit ok;
        for (int i = 0; i < 30; i++) pay_b[8*i +: 8] = 8'(8'h11 + 8'(i * 5));

        // Reset values.
        #12;
        check("rst_frame_ready_a", 32'(fr_a), 32'h0);
        check("rst_frame_ready_b", 32'(fr_b), 32'h0);
        check("rst_valid", 32'(mv_a), 32'h0);
        check("rst_last", 32'(ml_a), 32'h0);
        check("rst_data", 32'(md_a), 32'h0);
        @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        check("ready_after_release_a", 32'(fr_a), 32'h1);
        check("ready_after_release_b", 32'(fr_b), 32'h1);

        // Checksum/byte order, then two more back-to-back frames for the ID sequence.
        start_a(16'hBBAA, 16'h0000);
        wait_a();
        prev_end = last_edge_a;
        start_a(16'h1234, 16'h0001);
        check("a_back_to_back_capture", 32'(cap_a), 32'(prev_end + 1));
        wait_a();
        prev_end = last_edge_a;
        start_a(16'hC3A5, 16'h0002);
        check("a_back_to_back_capture2", 32'(cap_a), 32'(prev_end + 1));
        wait_a();

        // Random backpressure on both instances.
        bp = 1'b1;
        start_a(16'hBBAA, 16'h0003);
        wait_a();
        start_b(pay_b, 16'h0000);
        wait_b();
        bp = 1'b0;

        // Request while busy must be ignored.
        start_a(16'h6655, 16'h0004);
        repeat (8) @(negedge ACLK);
        check("a_ready_low_mid_frame", 32'(fr_a), 32'h0);
        frame_a = 16'h7777;
        fv_a = 1'b1;
        repeat (3) @(negedge ACLK);
        check("a_ready_low_during_ignored_req", 32'(fr_a), 32'h0);
        fv_a = 1'b0;
        wait_a();
        repeat (6) @(negedge ACLK);
        check("a_idle_after_ignored_req", 32'(mv_a), 32'h0);

        // Reset abort while byte 20 is presented.
        a0 = acc_a;
        start_a(16'h0201, 16'h0005);
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(posedge ACLK);
            #1;
            if (acc_a - a0 >= 20) begin ok = 1; break; end
        end
        if (!ok) fail_now("a_reach_byte20");
        check("a_valid_before_abort", 32'(mv_a), 32'h1);
        ARESET = 1'b0;
        #1;
        check("abort_valid_async", 32'(mv_a), 32'h0);
        check("abort_last_async", 32'(ml_a), 32'h0);
        check("abort_data_async", 32'(md_a), 32'h0);
        check("abort_ready_low", 32'(fr_a), 32'h0);
        q_a.delete();
        repeat (2) @(negedge ACLK);
        ARESET = 1'b1;
        start_a(16'hBBAA, 16'h0000);
        wait_a();
        start_b(pay_b, 16'h0000);
        wait_b();

        repeat (4) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ip_packet_tx.md
# ip_packet_tx

Transmit-side counterpart of the accelerator's IP receive path. It captures one user data frame, such as an inference result, together with destination addresses. It then streams a complete Ethernet II + IPv4 frame, one byte per beat, into the MAC's AXI-Stream transmit port. The block generates the IP header itself, including a per-frame identification counter and the header checksum, and zero-pads short payloads to the Ethernet minimum.

## Interface
- USER_DATA_BYTES, 2, payload bytes per frame (≥1).
- IP_PROTOCOL, 8'hFD, IPv4 protocol field value.
- IP_TTL, 8'd64, IPv4 TTL field value.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-low reset.
- ACCELERATOR_IP_ADDRESS  in  32  source IP, wire byte k at bits [8k+7:8k].
- ACCELERATOR_MAC_ADDRESS  in  48  source MAC, same byte order.
- DST_IP_ADDRESS  in  32  destination IP, same byte order.
- DST_MAC_ADDRESS  in  48  destination MAC, same byte order.
- DATA_FRAME  in  USER_DATA_BYTES*8  payload; byte k is sent k-th.
- FRAME_VALID  in  1  request to send DATA_FRAME.
- FRAME_READY  out  1  high only in IDLE; capture occurs on FRAME_VALID && FRAME_READY.
- MAC_DATA_IN  out  8  stream byte.
- MAC_DATA_VALID  out  1  byte valid.
- MAC_DATA_READY  in  1  MAC accepts byte.
- MAC_DATA_LAST  out  1  marks final byte of frame.

## Operation
- Reset values:
  - FRAME_READY=0 during reset, 1 in the first cycle after release (IDLE).
  - MAC_DATA_VALID=0, MAC_DATA_LAST=0, MAC_DATA_IN=0.
  - IP identification counter=0.
- Capture: all address and data inputs are registered on the capture handshake. Inputs are don't-care afterwards.
- States: IDLE → ETH_HDR (14 bytes) → IP_HDR (20 bytes) → USER_DATA (USER_DATA_BYTES) → PAD (max(0, 26−USER_DATA_BYTES) bytes of 0x00) → IDLE.
  - If no pad is needed, USER_DATA goes directly to IDLE.
  - A 16-bit byte counter advances only on MAC_DATA_VALID && MAC_DATA_READY. It clears on each state change.
- Ethernet header wire order: dst MAC bytes 0..5, src MAC bytes 0..5, 0x08, 0x00.
- IP header wire order:
  - 0x45, 0x00.
  - total length = 20+USER_DATA_BYTES, big-endian.
  - identification, big-endian.
  - 0x40, 0x00.
  - IP_TTL, IP_PROTOCOL.
  - checksum, big-endian.
  - src IP bytes 0..3, dst IP bytes 0..3.
- Total length excludes pad bytes.
- The identification counter increments by 1 (mod 2^16) when MAC_DATA_LAST is accepted.
- Checksum: one's-complement sum of the ten big-endian 16-bit header words, with the checksum word taken as 0.
  - Accumulated one word per clock, starting the cycle after capture and independent of MAC_DATA_READY.
  - Uses a 20-bit accumulator. End-around carries are folded twice, then the result is inverted.
  - Ready after 11 cycles, always before IP byte 10 is presented (earliest is 25 cycles after capture).
- AXI-Stream rules: once VALID is asserted, MAC_DATA_IN, VALID and LAST hold until accepted. There are no VALID bubbles inside a frame.
- MAC_DATA_LAST is asserted only on the final byte: the last pad byte, or the last data byte if there is no pad.
- FRAME_VALID is ignored while not in IDLE; no request queueing.
- Reset mid-frame aborts immediately: outputs go to reset values, no LAST is issued, and the identification counter is cleared.

## Timing
- Capture at cycle N: byte 0 (dst MAC byte 0) is presented with VALID at N+1.
- Frame length is F = 34 + max(USER_DATA_BYTES, 26) bytes. With READY held high, the last byte is accepted at N+F.
- FRAME_READY rises at N+F+1. The earliest next capture is N+F+1, giving one idle cycle between frames.
- READY low for k cycles extends the frame by exactly k cycles.

## Configuration
- IP_TX_CHECKSUM_EN defined: checksum computed and inserted as above.
- IP_TX_CHECKSUM_EN undefined: the accumulator is not built and checksum bytes are transmitted as 0x00, 0x00. All other bytes and timing are identical.

## Test plan
- Checksum and byte order: USER_DATA_BYTES=2, src IP 32'h0A01A8C0 (192.168.1.10), dst IP 32'h0101A8C0, ID=0, DATA_FRAME=16'hBBAA, READY=1. Required response:
  - 60-byte frame.
  - IP bytes 45 00 00 16 00 00 40 00 40 FD B6 8F C0 A8 01 0A C0 A8 01 01.
  - Then AA BB, then 24×00.
  - LAST only on byte 59; FRAME_READY high at N+61.
- Identification: three back-to-back frames → ID fields 0x0000, 0x0001, 0x0002. Checksum changes accordingly (second frame 0xB68E).
- Backpressure: random 50% READY → byte sequence identical to the READY=1 case. Data and LAST are held stable while VALID && !READY; the frame ends exactly k cycles later for k stall cycles.
- No pad: USER_DATA_BYTES=30 → 64-byte frame, total length 0x0032, LAST on data byte 29, no 0x00 pad bytes.
- Ignored request: FRAME_VALID pulsed mid-frame → no effect, FRAME_READY stays 0, no second frame.
- Reset abort: ARESET low at byte 20 → VALID and LAST drop asynchronously. The next frame after release starts at dst MAC byte 0 with ID=0.
